color_select: RTL and testbench

COLOR_SELECT -- requirements
Module: color_select

---
 rtl/color_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/color_select.sv | 100 ++++++++++
 tb/tb_color_select.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the palette colour selector.
package color_pkg;

   localparam int unsigned NUM_COLORS = 8;
   localparam int unsigned IDX_W      = $clog2(NUM_COLORS);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [11:0]      rgb444_t;

   typedef enum logic [1:0] {
      StManual,
      StAuto,
      StLocked
   } state_e;

   // Step a palette index by one in either direction; the index width gives the wrap.
   function automatic idx_t idx_step(input idx_t idx, input logic up);
      return up ? idx + idx_t'(1) : idx - idx_t'(1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_i,
   output logic rise_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      // Any sample matching the current level restarts the stability window.
      if (sync2_q != level_q) begin
         if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
      rise_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/color_select.sv
// Palette index selector: debounced next/prev buttons, demo auto-cycling and a
// game lock that freezes the selection. addr and changed are registered.
module color_select
   import color_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned AUTO_CYCLES     = 50_000_000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             auto_en,
   input  logic             lock,
   output logic [IDX_W-1:0] addr,
   output logic             changed
);

   localparam int unsigned PerW = $clog2(AUTO_CYCLES + 1);

   logic            next_rise, prev_rise;
   state_e          state_q, state_d;
   idx_t            addr_q, addr_d;
   logic            changed_q, changed_d;
   logic [PerW-1:0] per_q, per_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_next (
      .clk   (clk),
      .rstn  (rstn),
      .btn_i (btn_next),
      .rise_o(next_rise)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_prev (
      .clk   (clk),
      .rstn  (rstn),
      .btn_i (btn_prev),
      .rise_o(prev_rise)
   );

   always_comb begin
      if (lock) begin
         state_d = StLocked;
      end else if (auto_en) begin
         state_d = StAuto;
      end else begin
         state_d = StManual;
      end

      addr_d    = addr_q;
      changed_d = 1'b0;
      // Counter sits at 0 outside AUTO, so entering AUTO always starts a full period.
      per_d     = '0;

      case (state_q)
         StManual, StAuto: begin
            if (next_rise && !prev_rise) begin
               addr_d    = idx_step(addr_q, 1'b1);
               changed_d = 1'b1;
            end else if (prev_rise && !next_rise) begin
               addr_d    = idx_step(addr_q, 1'b0);
               changed_d = 1'b1;
            end

            // A manual press wins over a coincident tick and restarts the period.
            if (state_q == StAuto && !(next_rise || prev_rise)) begin
               if (per_q == PerW'(AUTO_CYCLES - 1)) begin
                  addr_d    = idx_step(addr_q, 1'b1);
                  changed_d = 1'b1;
               end else begin
                  per_d = per_q + PerW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StManual;
         addr_q    <= '0;
         changed_q <= 1'b0;
         per_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         changed_q <= changed_d;
         per_q     <= per_d;
      end
   end

   assign addr    = addr_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_color_select.sv
// Self-checking bench for color_select with short debounce and auto periods.
module tb_color_select;
   import color_pkg::*;

   localparam int unsigned DB = 4;
   localparam int unsigned AC = 16;

   logic       clk = 1'b0;
   logic       rstn, btn_next, btn_prev, auto_en, lock;
   logic [2:0] addr;
   logic       changed;

   always #5 clk = ~clk;

   color_select #(
      .DEBOUNCE_CYCLES(DB),
      .AUTO_CYCLES    (AC)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .auto_en (auto_en),
      .lock    (lock),
      .addr    (addr),
      .changed (changed)
   );

   typedef struct {
      logic       nxt;
      logic       prv;
      logic [2:0] exp_addr;
      logic       exp_chg;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         n_chg = 0;
   logic [2:0] exp_q[$];
   logic [2:0] prev_addr = 3'd0;
   vec_t       vecs[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      step(10);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      step(10);
   endtask

   task automatic wait_change(input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (changed) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         total++;
         bad++;
         $display("FAIL change_timeout: got none expected a change within %0d cycles", bound);
      end
   endtask

   // Scoreboard: every changed pulse must match the next queued expectation,
   // and addr must never move without changed.
   always @(negedge clk) begin
      if (rstn) begin
         if (changed) begin
            n_chg++;
            if (exp_q.size() == 0) check("change_without_expect", int'(changed), 0);
            else check("addr_on_change", int'(addr), int'(exp_q.pop_front()));
         end else begin
            check("addr_stable", int'(addr), int'(prev_addr));
         end
      end
      prev_addr = addr;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, at, t;

      vecs[0] = '{1'b0, 1'b1, 3'd0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 3'd7, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 3'd0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 3'd7, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 3'd6, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 3'd6, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 3'd7, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 3'd0, 1'b1};

      rstn = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; lock = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("reset_addr", int'(addr), 0);
      check("reset_changed", int'(changed), 0);
      step(3);
      check("reset_addr_held", int'(addr), 0);
      check("reset_state", int'(dut.state_q), int'(StManual));
      rstn = 1'b1;
      step(2);

      // First press: latency from raw edge and a single pulse.
      exp_q.push_back(3'd1);
      btn_next = 1'b1;
      c0 = cyc;
      wait_change(20, at);
      check_range("next_latency", at - c0, 7, 8);
      step(3);
      btn_next = 1'b0;
      step(12);
      check("first_addr", int'(addr), 1);
      check("first_pulses", n_chg, 1);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].exp_chg) exp_q.push_back(vecs[i].exp_addr);
         c0 = n_chg;
         press(vecs[i].nxt, vecs[i].prv);
         check($sformatf("vec%0d_addr", i), int'(addr), int'(vecs[i].exp_addr));
         check($sformatf("vec%0d_pulses", i), n_chg - c0, int'(vecs[i].exp_chg));
      end

      // Bouncing button shorter than the debounce window.
      c0 = n_chg;
      for (int i = 0; i < 10; i++) begin
         btn_next = ~btn_next;
         step(2);
      end
      btn_next = 1'b0;
      step(12);
      check("bounce_addr", int'(addr), 0);
      check("bounce_pulses", n_chg - c0, 0);

      // Lock discards presses, including one held across the lock release.
      c0 = n_chg;
      lock = 1'b1;
      step(2);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      btn_next = 1'b1;
      step(10);
      lock = 1'b0;
      step(5);
      btn_next = 1'b0;
      step(12);
      check("lock_addr", int'(addr), 0);
      check("lock_pulses", n_chg - c0, 0);

      // Auto-cycling period.
      exp_q.push_back(3'd1);
      auto_en = 1'b1;
      c0 = cyc;
      wait_change(40, at);
      check_range("auto_first_tick", at - c0, 16, 17);
      t = at;
      exp_q.push_back(3'd2);
      wait_change(40, at);
      check("auto_period", at - t, 16);
      t = at;

      // Press landing while the period counter is at 15.
      exp_q.push_back(3'd3);
      repeat (9) @(posedge clk);
      #1;
      btn_next = 1'b1;
      wait_change(20, at);
      check("press_at_15_time", at - t, 16);
      t = at;
      exp_q.push_back(3'd4);
      step(3);
      btn_next = 1'b0;
      wait_change(40, at);
      check("tick_after_press", at - t, 16);
      exp_q.push_back(3'd5);
      wait_change(40, at);
      check("auto_reach_5", int'(addr), 5);

      // Asynchronous reset in the middle of a period.
      step(5);
      rstn = 1'b0;
      #1;
      check("async_reset_addr", int'(addr), 0);
      check("async_reset_changed", int'(changed), 0);
      auto_en = 1'b0;
      step(2);
      rstn = 1'b1;
      step(3);
      check("post_reset_state", int'(dut.state_q), int'(StManual));
      c0 = n_chg;
      step(40);
      check("post_reset_addr", int'(addr), 0);
      check("post_reset_pulses", n_chg - c0, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
